// File: rtl/hazard_pkg.sv
// Shared encodings for the ID/EX hazard detector: FSM states, stall cause codes
// and the operand-match helper used by the load-use compare.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_WAIT  = 2'd1,
        DIV_BUSY = 2'd2
    } hazard_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_LOAD = 2'b01,
        CAUSE_DIV  = 2'b10
    } stall_cause_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so a write to it can never feed a later read.
    function automatic logic reg_dep(input logic       used,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
        return used && (rs == rd) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use and multi-cycle divide stall generator between ID and EX, with a
// saturating count of stalled cycles.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | no sequence in progress; new hazards may be raised
//   LU_WAIT  | load-use stall issued; ID/EX held, release cycle, hazard masked
//   DIV_BUSY | divide occupies EX; stall while div_cnt != 0, then release
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int DIV_LATENCY = 34,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_div_start,
    input  logic [1:0]       branch_jump_ex,
    input  logic             pc_sel_ex,
    output logic             stall_pipeline,
    output logic [1:0]       stall_cause,
    output logic             hazard_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // The first divide stall is issued from IDLE, so the counter covers the rest.
    localparam bit         DIV_STALLS = (DIV_LATENCY > 1);
    localparam logic [5:0] DIV_RELOAD = DIV_STALLS ? 6'(DIV_LATENCY - 2) : 6'd0;

    hazard_state_e state_q;
    hazard_state_e state_d;
    logic [5:0]    div_cnt_q;
    logic [5:0]    div_cnt_d;
    stall_cause_e  cause;
    logic          stall;
    logic          flush;
    logic          load_use;

    assign flush    = pc_sel_ex && (branch_jump_ex != 2'b00);
    assign load_use = ex_mem_read &&
                      (reg_dep(id_rs1_used, id_rs1, ex_rd) ||
                       reg_dep(id_rs2_used, id_rs2, ex_rd));

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        stall     = 1'b0;
        cause     = CAUSE_NONE;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (load_use) begin
                    stall   = 1'b1;
                    cause   = CAUSE_LOAD;
                    state_d = LU_WAIT;
                end else if (ex_div_start && DIV_STALLS) begin
                    stall     = 1'b1;
                    cause     = CAUSE_DIV;
                    div_cnt_d = DIV_RELOAD;
                    state_d   = DIV_BUSY;
                end
            end
            LU_WAIT: begin
                state_d = IDLE;
            end
            DIV_BUSY: begin
                if (flush) begin
                    div_cnt_d = 6'd0;
                    state_d   = IDLE;
                end else if (div_cnt_q != 6'd0) begin
                    stall     = 1'b1;
                    cause     = CAUSE_DIV;
                    div_cnt_d = div_cnt_q - 6'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                div_cnt_d = 6'd0;
                state_d   = IDLE;
            end
        endcase
        // A reset cycle must never leak a stall from an aborted sequence.
        if (reset) begin
            stall = 1'b0;
            cause = CAUSE_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= 6'd0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign stall_pipeline = stall;
    assign stall_cause    = cause;
    assign hazard_busy    = (state_q != IDLE);

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .clr_i  (reset),
        .inc_i  (stall),
        .count_o(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench: two hazard units (divide latency 4 / 4-bit counter, and
// latency 1 / 8-bit counter) share stimulus and are checked against a reference model.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_div_start, pc_sel_ex;
    logic [1:0] branch_jump_ex;

    logic       stall_a, busy_a, stall_b, busy_b;
    logic [1:0] cause_a, cause_b;
    logic [3:0] cnt_a;
    logic [7:0] cnt_b;

    always #5 clk = ~clk;

    hazard_detection_unit #(.DIV_LATENCY(4), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_div_start(ex_div_start),
        .branch_jump_ex(branch_jump_ex), .pc_sel_ex(pc_sel_ex),
        .stall_pipeline(stall_a), .stall_cause(cause_a), .hazard_busy(busy_a),
        .stall_cycles(cnt_a));

    hazard_detection_unit #(.DIV_LATENCY(1), .CNT_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_div_start(ex_div_start),
        .branch_jump_ex(branch_jump_ex), .pc_sel_ex(pc_sel_ex),
        .stall_pipeline(stall_b), .stall_cause(cause_b), .hazard_busy(busy_b),
        .stall_cycles(cnt_b));

    typedef struct {
        bit         stall_a;
        logic [1:0] cause_a;
        bit         busy_a;
        int         cnt_a;
        bit         stall_b;
        logic [1:0] cause_b;
        bit         busy_b;
        int         cnt_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: pending load release, divide stalls still owed, saturating count.
    bit a_lu_rel = 0, a_div_on = 0, b_lu_rel = 0, b_div_on = 0;
    int a_owed = 0, b_owed = 0, a_cnt = 0, b_cnt = 0;

    task automatic model(input int lat, input bit rst, input bit flush, input bit lu,
                         input bit dstart, inout bit lu_rel, inout bit div_on,
                         inout int owed, output bit stall, output logic [1:0] cause,
                         output bit busy);
        busy  = lu_rel || div_on;
        stall = 0;
        cause = 2'b00;
        if (rst) begin
            lu_rel = 0; div_on = 0; owed = 0;
        end else if (lu_rel) begin
            lu_rel = 0;
        end else if (div_on) begin
            if (flush || owed == 0) begin
                div_on = 0; owed = 0;
            end else begin
                stall = 1; cause = 2'b10; owed--;
            end
        end else if (flush) begin
            stall = 0;
        end else if (lu) begin
            stall = 1; cause = 2'b01; lu_rel = 1;
        end else if (dstart && lat > 1) begin
            // lat-1 stalls in total; this cycle pays the first one
            stall = 1; cause = 2'b10; div_on = 1; owed = lat - 2;
        end
    endtask

    task automatic cycle(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd, input bit mr,
                         input bit ds, input logic [1:0] bj, input bit ps);
        exp_t e;
        bit   lu, fl;
        reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_mem_read = mr; ex_div_start = ds; branch_jump_ex = bj; pc_sel_ex = ps;
        lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        fl = ps && bj != 2'b00;
        model(4, rst, fl, lu, ds, a_lu_rel, a_div_on, a_owed, e.stall_a, e.cause_a, e.busy_a);
        model(1, rst, fl, lu, ds, b_lu_rel, b_div_on, b_owed, e.stall_b, e.cause_b, e.busy_b);
        e.cnt_a = a_cnt;
        e.cnt_b = b_cnt;
        a_cnt = rst ? 0 : ((e.stall_a && a_cnt < 15)  ? a_cnt + 1 : a_cnt);
        b_cnt = rst ? 0 : ((e.stall_b && b_cnt < 255) ? b_cnt + 1 : b_cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 2'b00, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stall_a", int'(stall_a), int'(e.stall_a));
            chk("cause_a", int'(cause_a), int'(e.cause_a));
            chk("busy_a",  int'(busy_a),  int'(e.busy_a));
            chk("cnt_a",   int'(cnt_a),   e.cnt_a);
            chk("stall_b", int'(stall_b), int'(e.stall_b));
            chk("cause_b", int'(cause_b), int'(e.cause_b));
            chk("busy_b",  int'(busy_b),  int'(e.busy_b));
            chk("cnt_b",   int'(cnt_b),   e.cnt_b);
        end
    end

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd5;
            2:       return 5'd7;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        reset = 1; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; ex_rd = 0;
        ex_mem_read = 0; ex_div_start = 0; branch_jump_ex = 0; pc_sel_ex = 0;
        repeat (2) @(posedge clk);
        #1;
        idle(2);
        // load-use on rs1 held two cycles: one stall, then masked release
        cycle(0, 5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 2'b00, 0);
        cycle(0, 5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 2'b00, 0);
        idle(1);
        // x0 destination and unused rs2 never stall
        cycle(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 2'b00, 0);
        cycle(0, 5'd1, 5'd5, 1, 0, 5'd5, 1, 0, 2'b00, 0);
        // load-use through rs2, back-to-back pairs
        cycle(0, 5'd1, 5'd9, 0, 1, 5'd9, 1, 0, 2'b00, 0);
        cycle(0, 5'd1, 5'd9, 0, 1, 5'd9, 1, 0, 2'b00, 0);
        cycle(0, 5'd3, 5'd1, 1, 0, 5'd3, 1, 0, 2'b00, 0);
        cycle(0, 5'd3, 5'd1, 1, 0, 5'd3, 1, 0, 2'b00, 0);
        // divide held: 3 stalls, release, then a fresh divide starts
        for (int i = 0; i < 5; i++) cycle(0, 5'd1, 5'd2, 0, 0, 5'd4, 0, 1, 2'b00, 0);
        idle(4);
        // flush beats a same-cycle load-use
        cycle(0, 5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 2'b01, 1);
        idle(1);
        // flush during a divide stall releases at once
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd4, 0, 1, 2'b00, 0);
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd4, 0, 0, 2'b11, 1);
        idle(2);
        // reset in the second divide stall cycle aborts everything
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd4, 0, 1, 2'b00, 0);
        cycle(1, 5'd1, 5'd2, 0, 0, 5'd4, 0, 1, 2'b00, 0);
        idle(4);
        // continuous divides drive the 4-bit counter into saturation
        for (int i = 0; i < 30; i++) cycle(0, 5'd1, 5'd2, 0, 0, 5'd4, 0, 1, 2'b00, 0);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 49) == 0, pick_reg(), pick_reg(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_reg(),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end
        idle(2);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
